// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv shared types: op codes, FSM states, counter width.
package ex_muldiv_pkg;

   typedef enum logic [2:0] {
      MD_NONE  = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MTHI  = 3'd5,
      MD_MTLO  = 3'd6,
      MD_RSVD  = 3'd7
   } md_op_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_FIX
   } md_state_t;

   localparam int MD_WIDTH = 32;
   localparam int CNT_W    = $clog2(MD_WIDTH);

endpackage

// File: rtl/ex_muldiv_if.sv
// Request/result bundle between EX control and the mul/div unit.
interface ex_muldiv_if #(
   parameter int WIDTH = 32
) ();

   logic             i_EX_ctrl_MDValid;
   logic [2:0]       i_EX_ctrl_MDOp;
   logic [WIDTH-1:0] i_EX_data_A;
   logic [WIDTH-1:0] i_EX_data_B;
   logic             i_EX_ctrl_Flush;
   logic             o_EX_ctrl_Busy;
   logic [WIDTH-1:0] o_EX_data_HI;
   logic [WIDTH-1:0] o_EX_data_LO;
   logic             o_EX_data_Done;
   logic             o_EX_data_DivZero;

   modport master (
      output i_EX_ctrl_MDValid, i_EX_ctrl_MDOp,
      output i_EX_data_A, i_EX_data_B,
      output i_EX_ctrl_Flush,
      input  o_EX_ctrl_Busy, o_EX_data_HI,
      input  o_EX_data_LO, o_EX_data_Done,
      input  o_EX_data_DivZero
   );

   modport slave (
      input  i_EX_ctrl_MDValid, i_EX_ctrl_MDOp,
      input  i_EX_data_A, i_EX_data_B,
      input  i_EX_ctrl_Flush,
      output o_EX_ctrl_Busy, o_EX_data_HI,
      output o_EX_data_LO, o_EX_data_Done,
      output o_EX_data_DivZero
   );

endinterface

// File: rtl/ex_muldiv_core.sv
// Iterative shift-add multiply / restoring divide datapath
// with sign correction on the final result.
module muldiv_core
   import ex_muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   input  md_op_t           op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int W = WIDTH;

   logic [2*W-1:0] acc_q;
   logic [W-1:0]   dvs_q;
   logic           div_q;
   logic           neg_lo_q;
   logic           neg_hi_q;

   logic           sgn;
   logic           div_op;
   logic           a_neg;
   logic           b_neg;
   logic [W-1:0]   a_abs;
   logic [W-1:0]   b_abs;
   logic [W:0]     mul_sum;
   logic [W:0]     rem_sh;
   logic [W:0]     dif;
   logic [2*W-1:0] mul_nxt;
   logic [2*W-1:0] div_nxt;
   logic [2*W-1:0] prod;
   logic [W-1:0]   quo;
   logic [W-1:0]   rem;

   assign sgn    = (op == MD_MULT) || (op == MD_DIV);
   assign div_op = (op == MD_DIV) || (op == MD_DIVU);
   assign a_neg  = sgn & a[W-1];
   assign b_neg  = sgn & b[W-1];
   assign a_abs  = a_neg ? -a : a;
   assign b_abs  = b_neg ? -b : b;

   assign mul_sum = {1'b0, acc_q[2*W-1:W]}
                  + (acc_q[0] ? {1'b0, dvs_q}
                              : {(W+1){1'b0}});
   assign mul_nxt = {mul_sum, acc_q[W-1:1]};

   // Restoring step: keep the shifted remainder when it underflows.
   assign rem_sh  = {acc_q[2*W-1:W], acc_q[W-1]};
   assign dif     = rem_sh - {1'b0, dvs_q};
   assign div_nxt = dif[W]
                  ? {rem_sh[W-1:0], acc_q[W-2:0], 1'b0}
                  : {dif[W-1:0], acc_q[W-2:0], 1'b1};

   assign prod = neg_lo_q ? -acc_q : acc_q;
   assign quo  = neg_lo_q ? -acc_q[W-1:0] : acc_q[W-1:0];
   assign rem  = neg_hi_q ? -acc_q[2*W-1:W]
                          : acc_q[2*W-1:W];

   assign hi = div_q ? rem : prod[2*W-1:W];
   assign lo = div_q ? quo : prod[W-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q    <= '0;
         dvs_q    <= '0;
         div_q    <= 1'b0;
         neg_lo_q <= 1'b0;
         neg_hi_q <= 1'b0;
      end else if (load) begin
         div_q <= div_op;
         if (div_op && (b == '0)) begin
            // Divide by zero: result preloaded, no sign fix.
            acc_q    <= {a, {W{1'b1}}};
            dvs_q    <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
         end else if (div_op) begin
            acc_q    <= {{W{1'b0}}, a_abs};
            dvs_q    <= b_abs;
            neg_lo_q <= a_neg ^ b_neg;
            neg_hi_q <= a_neg;
         end else begin
            acc_q    <= {{W{1'b0}}, b_abs};
            dvs_q    <= a_abs;
            neg_lo_q <= a_neg ^ b_neg;
            neg_hi_q <= 1'b0;
         end
      end else if (step) begin
         acc_q <= div_q ? div_nxt : mul_nxt;
      end
   end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage multi-cycle mul/div unit: FSM, iteration counter,
// architectural HI/LO and completion pulses.
module ex_muldiv
   import ex_muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input logic        clk,
   input logic        rst,
   ex_muldiv_if.slave md
);

   localparam int CW = $clog2(WIDTH);

   md_state_t        state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] hi_q, lo_q;
   logic             busy_q, done_q, dz_q;
   logic             dz_pend_q;
   logic             load, step, fix_en;
   logic             wr_hi, wr_lo;
   logic             b_zero;
   md_op_t           op;
   logic [WIDTH-1:0] res_hi, res_lo;

   assign op     = md_op_t'(md.i_EX_ctrl_MDOp);
   assign b_zero = (md.i_EX_data_B == '0);

   muldiv_core #(.WIDTH(WIDTH)) u_core (
      .clk  (clk),
      .rst  (rst),
      .load (load),
      .step (step),
      .op   (op),
      .a    (md.i_EX_data_A),
      .b    (md.i_EX_data_B),
      .hi   (res_hi),
      .lo   (res_lo)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      load    = 1'b0;
      step    = 1'b0;
      fix_en  = 1'b0;
      wr_hi   = 1'b0;
      wr_lo   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (md.i_EX_ctrl_MDValid) begin
               case (op)
                  MD_MULT, MD_MULTU: begin
                     load    = 1'b1;
                     cnt_d   = CW'(WIDTH - 1);
                     state_d = S_MUL;
                  end
                  MD_DIV, MD_DIVU: begin
                     load    = 1'b1;
                     cnt_d   = CW'(WIDTH - 1);
                     state_d = b_zero ? S_FIX : S_DIV;
                  end
                  MD_MTHI: wr_hi = 1'b1;
                  MD_MTLO: wr_lo = 1'b1;
                  default: ;
               endcase
            end
         end
         S_MUL, S_DIV: begin
            step  = 1'b1;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0)
               state_d = S_FIX;
         end
         S_FIX: begin
            fix_en  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // Flush kills every side effect of this edge.
      if (md.i_EX_ctrl_Flush) begin
         state_d = S_IDLE;
         load    = 1'b0;
         step    = 1'b0;
         fix_en  = 1'b0;
         wr_hi   = 1'b0;
         wr_lo   = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         dz_q      <= 1'b0;
         dz_pend_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= (state_d != S_IDLE);
         done_q  <= fix_en;
         dz_q    <= fix_en & dz_pend_q;
         if (load)
            dz_pend_q <= b_zero
                       & ((op == MD_DIV) || (op == MD_DIVU));
         if (fix_en || wr_hi)
            hi_q <= fix_en ? res_hi : md.i_EX_data_A;
         if (fix_en || wr_lo)
            lo_q <= fix_en ? res_lo : md.i_EX_data_A;
      end
   end

   assign md.o_EX_ctrl_Busy    = busy_q;
   assign md.o_EX_data_HI      = hi_q;
   assign md.o_EX_data_LO      = lo_q;
   assign md.o_EX_data_Done    = done_q;
   assign md.o_EX_data_DivZero = dz_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: driver queues expected HI/LO,
// monitor pops and compares on every Done pulse.
module tb_ex_muldiv;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;
   exp_t sb[$];
   logic prev_done = 1'b0;

   ex_muldiv_if #(.WIDTH(32)) md ();

   ex_muldiv #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .md  (md)
   );

   always #5 clk = ~clk;

   task automatic chk(string name, logic [31:0] act,
                      logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Monitor: compare every completion against the scoreboard.
   always @(negedge clk) begin
      if (!rst && md.o_EX_data_Done === 1'b1) begin
         chk("done_one_cycle", 32'(prev_done), 32'd0);
         if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_done: HI=%h LO=%h",
                     md.o_EX_data_HI, md.o_EX_data_LO);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_hi", md.o_EX_data_HI, e.hi);
            chk("sb_lo", md.o_EX_data_LO, e.lo);
            chk("sb_divzero", 32'(md.o_EX_data_DivZero),
                32'(e.dz));
         end
      end
      prev_done = md.o_EX_data_Done;
   end

   task automatic issue_now(logic [2:0] op, logic [31:0] a,
                            logic [31:0] b);
      md.i_EX_ctrl_MDValid = 1'b1;
      md.i_EX_ctrl_MDOp    = op;
      md.i_EX_data_A       = a;
      md.i_EX_data_B       = b;
      @(negedge clk);
      md.i_EX_ctrl_MDValid = 1'b0;
      md.i_EX_ctrl_MDOp    = 3'd0;
   endtask

   task automatic issue(logic [2:0] op, logic [31:0] a,
                        logic [31:0] b);
      @(negedge clk);
      issue_now(op, a, b);
   endtask

   task automatic push(logic [31:0] hi, logic [31:0] lo,
                       logic dz);
      sb.push_back({hi, lo, dz});
   endtask

   // Counts busy cycles from the current negedge; bounded.
   task automatic wait_idle(output int n);
      n = 0;
      while (md.o_EX_ctrl_Busy === 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
      if (n >= 100) begin
         n_chk++;
         n_fail++;
         $display("FAIL busy_timeout: busy stuck after %0d", n);
      end
   endtask

   initial begin
      int n;
      logic [31:0] hi_s, lo_s;
      md.i_EX_ctrl_MDValid = 1'b0;
      md.i_EX_ctrl_MDOp    = 3'd0;
      md.i_EX_data_A       = '0;
      md.i_EX_data_B       = '0;
      md.i_EX_ctrl_Flush   = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_hi", md.o_EX_data_HI, 32'h0);
      chk("reset_lo", md.o_EX_data_LO, 32'h0);
      chk("reset_busy", 32'(md.o_EX_ctrl_Busy), 32'd0);
      chk("reset_done", 32'(md.o_EX_data_Done), 32'd0);

      push(32'hFFFFFFFE, 32'h00000001, 1'b0);
      issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_idle(n);
      chk("multu_busy_cycles", n, 33);
      @(negedge clk);
      chk("done_dropped", 32'(md.o_EX_data_Done), 32'd0);

      push(32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
      issue(3'd1, -32'sd3, 32'd7);
      wait_idle(n);

      push(32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
      issue(3'd3, -32'sd7, 32'd2);
      wait_idle(n);

      // Back-to-back: next request issued while Done is high.
      push(32'd2, 32'd14, 1'b0);
      issue(3'd4, 32'd100, 32'd7);
      wait_idle(n);
      chk("b2b_done_high", 32'(md.o_EX_data_Done), 32'd1);
      push(32'd0, 32'h80000000, 1'b0);
      issue_now(3'd3, 32'h80000000, 32'hFFFFFFFF);
      wait_idle(n);
      chk("div_ovf_busy_cycles", n, 33);

      push(32'd5, 32'hFFFFFFFF, 1'b1);
      issue(3'd4, 32'd5, 32'd0);
      wait_idle(n);
      chk("divzero_busy_cycles", n, 1);

      issue(3'd6, 32'h1234, 32'd0);
      chk("mtlo_lo", md.o_EX_data_LO, 32'h1234);
      chk("mtlo_busy", 32'(md.o_EX_ctrl_Busy), 32'd0);
      push(32'd0, 32'd12, 1'b0);
      issue(3'd2, 32'd3, 32'd4);
      repeat (2) @(negedge clk);
      issue_now(3'd2, 32'd5, 32'd5);
      wait_idle(n);
      repeat (40) @(negedge clk);
      chk("ignored_req_lo", md.o_EX_data_LO, 32'd12);

      // Flush on the 10th busy cycle.
      hi_s = md.o_EX_data_HI;
      lo_s = md.o_EX_data_LO;
      issue(3'd1, 32'd9, 32'd9);
      repeat (9) @(negedge clk);
      chk("flush_busy_before", 32'(md.o_EX_ctrl_Busy), 32'd1);
      md.i_EX_ctrl_Flush = 1'b1;
      @(negedge clk);
      md.i_EX_ctrl_Flush = 1'b0;
      chk("flush_busy", 32'(md.o_EX_ctrl_Busy), 32'd0);
      repeat (40) @(negedge clk);
      chk("flush_hi", md.o_EX_data_HI, hi_s);
      chk("flush_lo", md.o_EX_data_LO, lo_s);

      // Flush and Valid together: nothing accepted.
      md.i_EX_ctrl_Flush = 1'b1;
      issue(3'd5, 32'hDEADBEEF, 32'd0);
      md.i_EX_ctrl_Flush = 1'b0;
      chk("flush_wins_hi", md.o_EX_data_HI, hi_s);

      issue(3'd6, 32'h55, 32'd0);
      issue(3'd5, 32'hA5A5A5A5, 32'd0);
      chk("mthi_hi", md.o_EX_data_HI, 32'hA5A5A5A5);
      chk("mthi_lo", md.o_EX_data_LO, 32'h55);

      // Asynchronous reset in the middle of a divide.
      issue(3'd4, 32'd1000, 32'd3);
      repeat (5) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst_hi", md.o_EX_data_HI, 32'h0);
      chk("rst_lo", md.o_EX_data_LO, 32'h0);
      chk("rst_busy", 32'(md.o_EX_ctrl_Busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      chk("rst_no_resume", 32'(md.o_EX_ctrl_Busy), 32'd0);

      chk("sb_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
